// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types for the CNN tile datapath: data width, signed
//               pixel type and the tile MAC engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tile_mac_engine_mac_unit.sv
// ============================================================================
// Module      : mac_unit
// Description : Combinational signed multiply-add, sum = acc + a * b. The
//               product and the sum are both truncated to DATA_W bits, so
//               the result wraps modulo 2^DATA_W with no saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit
    import cnn_pkg::*;
(
    input  pixel_t acc,
    input  pixel_t a,
    input  pixel_t b,
    output pixel_t sum
);

    pixel_t prod;

    // Self-determined DATA_W-bit context keeps only the low product bits.
    assign prod = a * b;
    assign sum  = acc + prod;

endmodule

`default_nettype wire

// File: rtl/tile_mac_engine.sv
// ============================================================================
// Module      : tile_mac_engine
// Description : Computes one FILTER_SIZE x FILTER_SIZE dot product per tile
//               with a single time-multiplexed MAC and streams the per-tile
//               results out on a valid/ready handshake.
//               Optional build macro TILE_MAC_RELU_EN: when defined, each
//               result is clamped to max(sum, 0) before it is emitted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_mac_engine
    import cnn_pkg::*;
#(
    parameter int SIZE        = 9,
    parameter int FILTER_SIZE = 3,
    localparam int NT         = (SIZE / FILTER_SIZE) ** 2,
    localparam int IDX_W      = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [0:NT-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1][DATA_W-1:0] tiles_in,
    input  logic [0:FILTER_SIZE-1][0:FILTER_SIZE-1][DATA_W-1:0]         kernel,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   done
);

    localparam int RC_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam logic [RC_W-1:0]  LAST_RC   = RC_W'(FILTER_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_TILE = IDX_W'(NT - 1);

    state_t state;
    state_t state_next;

    // Snapshot of the operands taken when a run starts.
    logic [0:NT-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1][DATA_W-1:0] tile_reg;
    logic [0:FILTER_SIZE-1][0:FILTER_SIZE-1][DATA_W-1:0]         kernel_reg;

    pixel_t           acc;
    logic [IDX_W-1:0] tile;
    // Element counter kept as row/col so it indexes the arrays directly;
    // elem = row*FILTER_SIZE + col.
    logic [RC_W-1:0]  row;
    logic [RC_W-1:0]  col;

    pixel_t           mac_sum;
    pixel_t           result;
    logic             last_elem;
    logic             handshake;

    assign last_elem = (row == LAST_RC) && (col == LAST_RC);
    assign handshake = (state == EMIT) && out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    mac_unit u_mac (
        .acc (acc),
        .a   (pixel_t'(tile_reg[tile][row][col])),
        .b   (pixel_t'(kernel_reg[row][col])),
        .sum (mac_sum)
    );

`ifdef TILE_MAC_RELU_EN
    assign result = mac_sum[DATA_W-1] ? '0 : mac_sum;
`else
    assign result = mac_sum;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = MAC;
            MAC:  if (last_elem) state_next = EMIT;
            EMIT: if (handshake) state_next = (tile == LAST_TILE) ? DONE : MAC;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand snapshot; no reset needed since it is only read after a load.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            tile_reg   <= tiles_in;
            kernel_reg <= kernel;
        end
    end

    // Accumulator, counters and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            tile      <= '0;
            row       <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        tile <= '0;
                        row  <= '0;
                        col  <= '0;
                    end
                end
                MAC: begin
                    acc <= mac_sum;
                    if (col == LAST_RC) begin
                        col <= '0;
                        row <= (row == LAST_RC) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (last_elem) begin
                        out_data  <= result;
                        out_idx   <= tile;
                        out_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (tile != LAST_TILE) begin
                            tile <= tile + 1'b1;
                            acc  <= '0;
                            row  <= '0;
                            col  <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
